tt_um_ksa_seq16: RTL and testbench

TT_UM_KSA_SEQ16 -- requirements
Module: tt_um_ksa_seq16

---
 rtl/tt_um_ksa_seq16.sv | 115 +++++++++++
 tb/tb_tt_um_ksa_seq16.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_ksa_seq16.sv
// Sequential 16-bit adder that reuses one 4-bit Kogge-Stone slice over four cycles,
// starting with the least-significant nibble. Operands are loaded one byte at a time.
module tt_um_ksa_seq16 (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t      state;
  logic [1:0]  slice_idx;
  logic        carry;
  logic        cout;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] sum;

  logic       wr;
  logic [1:0] addr;
  logic       start;
  logic       cin;
  logic       unused_uio_in;

  assign wr            = uio_in[0];
  assign addr          = uio_in[2:1];
  assign start         = uio_in[3];
  assign cin           = uio_in[4];
  assign unused_uio_in = &{1'b0, uio_in[7:5]};

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] nib_sum;
  logic       nib_cout;

  assign a_nib = a[{slice_idx, 2'b00} +: 4];
  assign b_nib = b[{slice_idx, 2'b00} +: 4];

  // Prefix network over 5 positions: position 0 is the incoming carry acting as a
  // generate with no propagate, so gk[i] ends up as the carry into nibble bit i.
  logic [4:0] g0, p0, g1, p1, g2, p2, gk;

  always_comb begin
    g0 = {a_nib & b_nib, carry};
    p0 = {a_nib ^ b_nib, 1'b0};
    g1 = g0;
    p1 = p0;
    for (int i = 1; i < 5; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end
    g2 = g1;
    p2 = p1;
    for (int i = 2; i < 5; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end
    gk    = g2;
    gk[4] = g2[4] | (p2[4] & g2[0]);
    nib_sum  = p0[4:1] ^ gk[3:0];
    nib_cout = gk[4];
  end

  // Byte writes land on the same edge as an accepted start, so the new byte is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      slice_idx <= 2'd0;
      carry     <= 1'b0;
      cout      <= 1'b0;
      a         <= 16'h0000;
      b         <= 16'h0000;
      sum       <= 16'h0000;
    end else if (ena) begin
      if (wr && state != ADD) begin
        case (addr)
          2'd0: a[7:0]  <= ui_in;
          2'd1: a[15:8] <= ui_in;
          2'd2: b[7:0]  <= ui_in;
          2'd3: b[15:8] <= ui_in;
          default: ;
        endcase
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= ADD;
            slice_idx <= 2'd0;
            carry     <= cin;
          end
        end
        ADD: begin
          sum[{slice_idx, 2'b00} +: 4] <= nib_sum;
          carry     <= nib_cout;
          slice_idx <= slice_idx + 2'd1;
          if (slice_idx == 2'd3) begin
            state <= DONE;
            cout  <= nib_cout;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uo_out  = addr[0] ? sum[15:8] : sum[7:0];
  assign uio_out = {state == DONE, state == ADD, cout, 5'b00000};
  assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_ksa_seq16.sv
// Self-checking bench for tt_um_ksa_seq16: a vector table of additions plus hand-written
// sequences for busy-state writes, ena stalls and reset aborts; results go through a scoreboard.
module tb_tt_um_ksa_seq16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       wr = 1'b0;
  logic [1:0] addr = 2'd0;
  logic       start = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign uio_in = {3'b000, cin, start, addr, wr};

  tt_um_ksa_seq16 dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t        vecs[7];
  logic [16:0] exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic writeByte(input logic [1:0] ad, input logic [7:0] d);
    wr = 1'b1;
    addr = ad;
    ui_in = d;
    tick();
    wr = 1'b0;
    addr = 2'd0;
  endtask

  task automatic loadOperands(input logic [15:0] a, input logic [15:0] b);
    writeByte(2'd0, a[7:0]);
    writeByte(2'd1, a[15:8]);
    writeByte(2'd2, b[7:0]);
    writeByte(2'd3, b[15:8]);
  endtask

  task automatic readSum(output logic [15:0] s);
    addr = 2'd0;
    #1 s[7:0] = uo_out;
    addr = 2'd1;
    #1 s[15:8] = uo_out;
    addr = 2'd0;
    #1;
  endtask

  // Any write fields already set by the caller are sampled on the same edge as start.
  task automatic startOp(input logic c, input logic [16:0] expv);
    cin = c;
    start = 1'b1;
    exp_q.push_back(expv);
    tick();
    start = 1'b0;
    cin = 1'b0;
    wr = 1'b0;
    addr = 2'd0;
  endtask

  task automatic waitDone(input string name, input int want_cycles);
    int cycles = 0;
    while (!uio_out[7] && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput({name, " cycles to done"}, cycles, want_cycles);
  endtask

  task automatic checkResult(input string name);
    logic [16:0] e;
    logic [15:0] s;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL %s: scoreboard empty, got done=%0b, want a queued result", name, uio_out[7]);
    end else begin
      e = exp_q.pop_front();
      readSum(s);
      checkOutput({name, " sum"}, s, e[15:0]);
      checkOutput({name, " cout"}, uio_out[5], e[16]);
      checkOutput({name, " status"}, {uio_out[7:6], uio_out[4:0]}, 7'b1000000);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    loadOperands(v.a, v.b);
    startOp(v.cin, {v.cout, v.sum});
    checkOutput({name, " busy after start"}, uio_out[7:6], 2'b01);
    waitDone(name, 4);
    checkResult(name);
  endtask

  initial begin
    logic [15:0] s;
    int done_seen;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};

    #1;
    checkOutput("reset uo_out", uo_out, 8'h00);
    checkOutput("reset uio_out", uio_out, 8'h00);
    checkOutput("reset uio_oe", uio_oe, 8'hE0);
    #12 rst_n = 1'b1;
    tick();
    readSum(s);
    checkOutput("idle sum after reset", s, 16'h0000);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Write and start during ADD must both be ignored.
    loadOperands(16'h1234, 16'h4321);
    startOp(1'b0, 17'h05555);
    tick();
    start = 1'b1;
    writeByte(2'd2, 8'hAA);
    start = 1'b0;
    waitDone("busy ignore", 2);
    checkResult("busy ignore");

    writeByte(2'd3, 8'h43);
    checkOutput("done held after write", uio_out[7:6], 2'b10);
    readSum(s);
    checkOutput("sum held after write", s, 16'h5555);

    // Same-edge write and start: the new A low byte takes part in the addition.
    wr = 1'b1;
    addr = 2'd0;
    ui_in = 8'hFF;
    startOp(1'b0, 17'h05620);
    waitDone("write+start", 4);
    checkResult("write+start");

    // Stall mid-ADD with ena low after two slices.
    loadOperands(16'h00FF, 16'h0001);
    startOp(1'b0, 17'h00100);
    tick();
    tick();
    ena = 1'b0;
    repeat (5) tick();
    checkOutput("stall status", uio_out[7:6], 2'b01);
    readSum(s);
    checkOutput("stall partial sum", s, 16'h5600);
    ena = 1'b1;
    waitDone("stall resume", 2);
    checkResult("stall resume");

    // Asynchronous reset in the middle of an addition.
    loadOperands(16'h1111, 16'h2222);
    startOp(1'b0, 17'h03333);
    tick();
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async reset uo_out lo", uo_out, 8'h00);
    checkOutput("async reset uio_out", uio_out, 8'h00);
    checkOutput("async reset uio_oe", uio_oe, 8'hE0);
    void'(exp_q.pop_back());
    tick();
    #1 rst_n = 1'b1;
    readSum(s);
    checkOutput("sum cleared by reset", s, 16'h0000);
    done_seen = 0;
    repeat (8) begin
      tick();
      if (uio_out[7] || uio_out[6]) done_seen++;
    end
    checkOutput("no done/busy after reset", done_seen, 0);

    applyStimulus('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0}, "post reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, got no end, want end");
    $fatal(1, "[TB] timeout");
  end

endmodule
